// File: rtl/i2c_slave.sv
// ----------------------------------------------------------------------------
// i2c_slave
//
// I2C target that answers our own I2C master on a shared two-wire bus.
// SCL and SDA are oversampled on clk. Each line is synchronised, then
// glitch-filtered. START/STOP and bit edges are found on the filtered
// levels.
//
// Only SDA is driven, and only open-drain ('0' or 'Z'). SCL is never
// driven, so there is no clock stretching. Received write bytes land in
// rx_data. Read bytes come from tx_data, which is requested one byte ahead
// through tx_req.
//
// Ports
//   clk        system clock, must run at 20x SCL or faster
//   rst_n      asynchronous active-low reset
//   slv_addr   own 7-bit address, compared during the address byte
//   scl        bus clock (input only)
//   sda        bus data, open-drain
//   rx_data    last byte accepted from the master
//   rx_valid   one-clk pulse when rx_data updates
//   rx_ready   high = accept (ACK) the next write byte, low = NACK it
//   tx_data    byte to be returned on a read
//   tx_req     one-clk pulse asking for the next tx_data
//   busy       high from a matched address until STOP / repeated START
//   rd_mode    R/W bit of the current addressed transfer (1 = read)
//   nack_rcvd  one-clk pulse when the master NACKs a read byte
// ----------------------------------------------------------------------------
module i2c_slave #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] slv_addr,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       busy,
   output logic       rd_mode,
   output logic       nack_rcvd
);

   localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int FL = (FILTER_LEN < 1) ? 1 : FILTER_LEN;
   localparam int CW = $clog2(FL + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FL - 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [SS-1:0] scl_sync;
   logic [SS-1:0] sda_sync;
   logic          sclf;
   logic          sdaf;
   logic          sclf_d;
   logic          sdaf_d;
   logic [CW-1:0] scl_cnt;
   logic [CW-1:0] sda_cnt;

   logic          scl_rise;
   logic          scl_fall;
   logic          start_det;
   logic          stop_det;

   logic [2:0]    bit_cnt;
   logic [6:0]    shreg;
   logic [6:0]    txsh;
   logic          sda_low;
   logic          byte_done;
   logic          ack_pend;

   logic [2:0]    bit_cnt_n;
   logic [6:0]    shreg_n;
   logic [6:0]    txsh_n;
   logic          sda_low_n;
   logic          byte_done_n;
   logic          ack_pend_n;
   logic [7:0]    rx_data_n;
   logic          rx_valid_n;
   logic          tx_req_n;
   logic          busy_n;
   logic          rd_mode_n;
   logic          nack_n;

   logic [7:0]    byte_in;
   logic          last_bit;
   logic          addr_match;

   // Open-drain pad. A '1' bit is sent by releasing the line, never by
   // driving it high.
   assign sda = sda_low ? 1'b0 : 1'bz;

   // Metastability synchronisers for both bus lines. They reset to '1'
   // because an idle I2C bus is pulled high. This avoids a false edge
   // when reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         scl_sync <= {scl_sync[SS-2:0], scl};
         sda_sync <= {sda_sync[SS-2:0], sda};
      end
   end

   // Glitch filter. A filtered level follows its synchronised line only
   // after the line has held the new value for FILTER_LEN clocks in a row.
   // Any return to the old value restarts the count. The same delay is
   // applied to both lines, so SDA-versus-SCL ordering is preserved.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclf    <= 1'b1;
         sdaf    <= 1'b1;
         scl_cnt <= '0;
         sda_cnt <= '0;
      end else begin
         if (scl_sync[SS-1] == sclf) begin
            scl_cnt <= '0;
         end else if (scl_cnt == CNT_MAX) begin
            sclf    <= scl_sync[SS-1];
            scl_cnt <= '0;
         end else begin
            scl_cnt <= scl_cnt + CW'(1);
         end

         if (sda_sync[SS-1] == sdaf) begin
            sda_cnt <= '0;
         end else if (sda_cnt == CNT_MAX) begin
            sdaf    <= sda_sync[SS-1];
            sda_cnt <= '0;
         end else begin
            sda_cnt <= sda_cnt + CW'(1);
         end
      end
   end

   // Delayed copies of the filtered levels, used for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclf_d <= 1'b1;
         sdaf_d <= 1'b1;
      end else begin
         sclf_d <= sclf;
         sdaf_d <= sdaf;
      end
   end

   // Bus events. START and STOP need SCL high on both samples, so an SDA
   // change that coincides with an SCL edge is never taken as a condition.
   assign scl_rise   = sclf & ~sclf_d;
   assign scl_fall   = ~sclf & sclf_d;
   assign start_det  = sclf & sclf_d & sdaf_d & ~sdaf;
   assign stop_det   = sclf & sclf_d & ~sdaf_d & sdaf;

   // Byte assembly helpers. byte_in is the complete byte as it stands on
   // the 8th rising edge: the 7 bits already shifted plus the bit on SDA.
   assign byte_in    = {shreg, sdaf};
   assign last_bit   = scl_rise && (bit_cnt == 3'd0);
   assign addr_match = (shreg == slv_addr);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. STOP and START override anything the current state
   // would do in the same clock. A partial byte is therefore simply
   // abandoned.
   always_comb begin
      state_nxt = state;
      if (stop_det) begin
         state_nxt = IDLE;
      end else if (start_det) begin
         state_nxt = ADDR;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = IDLE;
            end
            ADDR: begin
               if (last_bit && !byte_done && !addr_match) begin
                  state_nxt = WAIT_STOP;
               end else if (byte_done && scl_fall) begin
                  state_nxt = ADDR_ACK;
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  state_nxt = rd_mode ? RD_DATA : WR_DATA;
               end
            end
            WR_DATA: begin
               if (byte_done && scl_fall) begin
                  state_nxt = WR_ACK;
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  state_nxt = WR_DATA;
               end
            end
            RD_DATA: begin
               if (scl_fall && (bit_cnt == 3'd0)) begin
                  state_nxt = RD_ACK;
               end
            end
            RD_ACK: begin
               if (scl_rise && !byte_done && sdaf) begin
                  state_nxt = WAIT_STOP;
               end else if (byte_done && scl_fall) begin
                  state_nxt = RD_DATA;
               end
            end
            WAIT_STOP: begin
               state_nxt = WAIT_STOP;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Output and datapath logic. SDA is only sampled on scl_rise and the
   // SDA drive only changes on scl_fall. byte_done marks "8th bit (or ACK
   // bit) seen, act on the coming falling edge". It keeps the action
   // inside the same state until SCL goes low. Pulses default to zero.
   always_comb begin
      bit_cnt_n   = bit_cnt;
      shreg_n     = shreg;
      txsh_n      = txsh;
      sda_low_n   = sda_low;
      byte_done_n = byte_done;
      ack_pend_n  = ack_pend;
      rx_data_n   = rx_data;
      busy_n      = busy;
      rd_mode_n   = rd_mode;
      rx_valid_n  = 1'b0;
      tx_req_n    = 1'b0;
      nack_n      = 1'b0;

      if (stop_det || start_det) begin
         sda_low_n   = 1'b0;
         busy_n      = 1'b0;
         byte_done_n = 1'b0;
         bit_cnt_n   = 3'd7;
      end else begin
         case (state)
            ADDR: begin
               if (scl_rise && !byte_done) begin
                  shreg_n = byte_in[6:0];
                  if (bit_cnt == 3'd0) begin
                     if (addr_match) begin
                        rd_mode_n   = sdaf;
                        busy_n      = 1'b1;
                        byte_done_n = 1'b1;
                     end
                  end else begin
                     bit_cnt_n = bit_cnt - 3'd1;
                  end
               end
               if (byte_done && scl_fall) begin
                  sda_low_n   = 1'b1;
                  byte_done_n = 1'b0;
               end
            end
            ADDR_ACK: begin
               if (scl_rise && rd_mode) begin
                  tx_req_n = 1'b1;
               end
               if (scl_fall) begin
                  bit_cnt_n = 3'd7;
                  if (rd_mode) begin
                     txsh_n    = tx_data[6:0];
                     sda_low_n = ~tx_data[7];
                  end else begin
                     sda_low_n = 1'b0;
                  end
               end
            end
            WR_DATA: begin
               if (scl_rise && !byte_done) begin
                  shreg_n = byte_in[6:0];
                  if (bit_cnt == 3'd0) begin
                     byte_done_n = 1'b1;
                     ack_pend_n  = rx_ready;
                     if (rx_ready) begin
                        rx_data_n  = byte_in;
                        rx_valid_n = 1'b1;
                     end
                  end else begin
                     bit_cnt_n = bit_cnt - 3'd1;
                  end
               end
               if (byte_done && scl_fall) begin
                  sda_low_n   = ack_pend;
                  byte_done_n = 1'b0;
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  sda_low_n = 1'b0;
                  bit_cnt_n = 3'd7;
               end
            end
            RD_DATA: begin
               if (scl_fall) begin
                  if (bit_cnt == 3'd0) begin
                     sda_low_n = 1'b0;
                  end else begin
                     bit_cnt_n = bit_cnt - 3'd1;
                     sda_low_n = ~txsh[6];
                     txsh_n    = {txsh[5:0], 1'b0};
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise && !byte_done) begin
                  if (sdaf) begin
                     nack_n = 1'b1;
                  end else begin
                     tx_req_n    = 1'b1;
                     byte_done_n = 1'b1;
                  end
               end
               if (byte_done && scl_fall) begin
                  txsh_n      = tx_data[6:0];
                  sda_low_n   = ~tx_data[7];
                  bit_cnt_n   = 3'd7;
                  byte_done_n = 1'b0;
               end
            end
            IDLE, WAIT_STOP: begin
               sda_low_n = 1'b0;
            end
            default: begin
               sda_low_n = 1'b0;
            end
         endcase
      end
   end

   // Datapath and output registers. Reset releases SDA at once and
   // returns the bit counter to the MSB position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= 3'd7;
         shreg     <= '0;
         txsh      <= '0;
         sda_low   <= 1'b0;
         byte_done <= 1'b0;
         ack_pend  <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         busy      <= 1'b0;
         rd_mode   <= 1'b0;
         nack_rcvd <= 1'b0;
      end else begin
         bit_cnt   <= bit_cnt_n;
         shreg     <= shreg_n;
         txsh      <= txsh_n;
         sda_low   <= sda_low_n;
         byte_done <= byte_done_n;
         ack_pend  <= ack_pend_n;
         rx_data   <= rx_data_n;
         rx_valid  <= rx_valid_n;
         tx_req    <= tx_req_n;
         busy      <= busy_n;
         rd_mode   <= rd_mode_n;
         nack_rcvd <= nack_n;
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// ----------------------------------------------------------------------------
// tb_i2c_slave
//
// Bit-banged I2C master around i2c_slave, with an open-drain SDA and a
// pull-up. One SCL quarter period is Q system clocks. All driving and
// sampling happens on the falling edge of clk.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave;

   localparam int Q = 10;

   logic       clk;
   logic       rst_n;
   logic [6:0] slv_addr;
   logic       scl_m;
   logic       m_sda_low;
   wire        sda;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       busy;
   logic       rd_mode;
   logic       nack_rcvd;

   logic       glitch_scl;
   logic       glitch_sda;
   logic       ack;
   logic [7:0] d;

   int checks = 0;
   int failures = 0;

   int rxv_cnt = 0;
   int txr_cnt = 0;
   int nack_cnt = 0;
   int busy_cnt = 0;
   int drove_cnt = 0;
   logic [7:0] rx_hist[$];

   int base_rx;
   int base_tx;
   int base_nk;
   int base_busy;
   int base_drv;

   assign sda = m_sda_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_slave #(
      .SYNC_STAGES (2),
      .FILTER_LEN  (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .slv_addr  (slv_addr),
      .scl       (scl_m),
      .sda       (sda),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_data   (tx_data),
      .tx_req    (tx_req),
      .busy      (busy),
      .rd_mode   (rd_mode),
      .nack_rcvd (nack_rcvd)
   );

   // System clock, 100 MHz.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends on its own.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached before end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   // Event monitor. Counts pulses and logs every accepted byte. Also counts
   // clocks where SDA is low while the master is not pulling it.
   always @(negedge clk) begin
      if (rx_valid) begin
         rxv_cnt++;
         rx_hist.push_back(rx_data);
      end
      if (tx_req) txr_cnt++;
      if (nack_rcvd) nack_cnt++;
      if (busy) busy_cnt++;
      if (!m_sda_low && (sda === 1'b0)) drove_cnt++;
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   // START from idle, or repeated START when SCL is currently low.
   task automatic i2c_start();
      if (scl_m == 1'b0) begin
         m_sda_low = 1'b0;
         wait_q();
         scl_m = 1'b1;
         wait_q();
      end
      m_sda_low = 1'b1;
      wait_q();
      scl_m = 1'b0;
      wait_q();
   endtask

   task automatic i2c_stop();
      m_sda_low = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      m_sda_low = 1'b0;
      wait_q();
      wait_q();
   endtask

   // One master-driven bit. Optional 1-clk glitches: an SCL pulse in the
   // low phase, and an SDA low pulse in the high phase of a '1' bit.
   task automatic send_bit(input logic b);
      m_sda_low = ~b;
      if (glitch_scl) begin
         repeat (3) @(negedge clk);
         scl_m = 1'b1;
         @(negedge clk);
         scl_m = 1'b0;
         repeat (Q - 4) @(negedge clk);
      end else begin
         wait_q();
      end
      scl_m = 1'b1;
      if (glitch_sda && b) begin
         wait_q();
         m_sda_low = 1'b1;
         @(negedge clk);
         m_sda_low = 1'b0;
         repeat (Q - 1) @(negedge clk);
      end else begin
         wait_q();
         wait_q();
      end
      scl_m = 1'b0;
      wait_q();
   endtask

   task automatic recv_bit(output logic b);
      m_sda_low = 1'b0;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      b = sda;
      wait_q();
      scl_m = 1'b0;
      wait_q();
   endtask

   // Eight data bits MSB first, then the ACK slot. a = sampled SDA (0 = ACK).
   task automatic write_byte(input logic [7:0] v, output logic a);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      recv_bit(a);
   endtask

   task automatic read_byte(input logic master_nack, output logic [7:0] v);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         v[i] = b;
      end
      send_bit(master_nack);
   endtask

   initial begin
      rst_n      = 1'b0;
      scl_m      = 1'b1;
      m_sda_low  = 1'b0;
      slv_addr   = 7'h42;
      rx_ready   = 1'b1;
      tx_data    = 8'h00;
      glitch_scl = 1'b0;
      glitch_sda = 1'b0;
      repeat (4) @(negedge clk);

      // Reset state.
      checkOutput("reset_rx_data", rx_data, 8'h00);
      checkOutput("reset_rx_valid", rx_valid, 1'b0);
      checkOutput("reset_tx_req", tx_req, 1'b0);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_rd_mode", rd_mode, 1'b0);
      checkOutput("reset_nack_rcvd", nack_rcvd, 1'b0);
      checkOutput("reset_sda", sda, 1'b1);
      rst_n = 1'b1;
      wait_q();
      $display("[TB] reset released");

      // Write to 0x42: two data bytes, both accepted.
      base_rx = rxv_cnt;
      i2c_start();
      write_byte(8'h84, ack);
      checkOutput("t1_addr_ack", ack, 1'b0);
      checkOutput("t1_busy", busy, 1'b1);
      checkOutput("t1_rd_mode", rd_mode, 1'b0);
      write_byte(8'hA5, ack);
      checkOutput("t1_data1_ack", ack, 1'b0);
      write_byte(8'h5A, ack);
      checkOutput("t1_data2_ack", ack, 1'b0);
      checkOutput("t1_busy_before_stop", busy, 1'b1);
      i2c_stop();
      checkOutput("t1_busy_after_stop", busy, 1'b0);
      checkOutput("t1_rx_valid_count", rxv_cnt - base_rx, 2);
      checkOutput("t1_rx_byte1", rx_hist[base_rx], 8'hA5);
      checkOutput("t1_rx_byte2", rx_hist[base_rx + 1], 8'h5A);
      checkOutput("t1_rx_data", rx_data, 8'h5A);

      // Foreign address 0x43 is ignored, then a repeated START to 0x42 is ACKed.
      base_rx   = rxv_cnt;
      base_busy = busy_cnt;
      base_drv  = drove_cnt;
      i2c_start();
      write_byte(8'h86, ack);
      checkOutput("t2_addr_nack", ack, 1'b1);
      write_byte(8'h77, ack);
      checkOutput("t2_data_nack", ack, 1'b1);
      checkOutput("t2_busy_clocks", busy_cnt - base_busy, 0);
      checkOutput("t2_sda_driven_clocks", drove_cnt - base_drv, 0);
      checkOutput("t2_rx_valid_count", rxv_cnt - base_rx, 0);
      i2c_start();
      write_byte(8'h84, ack);
      checkOutput("t2_readdress_ack", ack, 1'b0);
      checkOutput("t2_readdress_busy", busy, 1'b1);
      i2c_stop();

      // Read two bytes: master ACKs the first, NACKs the second.
      base_tx = txr_cnt;
      base_nk = nack_cnt;
      tx_data = 8'h3C;
      i2c_start();
      write_byte(8'h85, ack);
      checkOutput("t3_addr_ack", ack, 1'b0);
      checkOutput("t3_rd_mode", rd_mode, 1'b1);
      tx_data = 8'hC3;
      read_byte(1'b0, d);
      checkOutput("t3_read_byte1", d, 8'h3C);
      read_byte(1'b1, d);
      checkOutput("t3_read_byte2", d, 8'hC3);
      i2c_stop();
      checkOutput("t3_tx_req_count", txr_cnt - base_tx, 2);
      checkOutput("t3_nack_count", nack_cnt - base_nk, 1);
      checkOutput("t3_busy_after_stop", busy, 1'b0);

      // rx_ready low on the second byte: NACKed and discarded.
      base_rx = rxv_cnt;
      i2c_start();
      write_byte(8'h84, ack);
      checkOutput("t4_addr_ack", ack, 1'b0);
      write_byte(8'h11, ack);
      checkOutput("t4_data1_ack", ack, 1'b0);
      rx_ready = 1'b0;
      write_byte(8'h22, ack);
      checkOutput("t4_data2_nack", ack, 1'b1);
      checkOutput("t4_rx_data_kept", rx_data, 8'h11);
      checkOutput("t4_rx_valid_count", rxv_cnt - base_rx, 1);
      i2c_stop();
      rx_ready = 1'b1;

      // Write, then repeated START into a one-byte read.
      i2c_start();
      write_byte(8'h84, ack);
      checkOutput("t5_wr_addr_ack", ack, 1'b0);
      checkOutput("t5_rd_mode_write", rd_mode, 1'b0);
      write_byte(8'h66, ack);
      checkOutput("t5_wr_data_ack", ack, 1'b0);
      i2c_start();
      checkOutput("t5_busy_after_rstart", busy, 1'b0);
      tx_data = 8'h9E;
      write_byte(8'h85, ack);
      checkOutput("t5_rd_addr_ack", ack, 1'b0);
      checkOutput("t5_rd_mode_read", rd_mode, 1'b1);
      read_byte(1'b1, d);
      checkOutput("t5_read_byte", d, 8'h9E);
      i2c_stop();
      checkOutput("t5_rx_data", rx_data, 8'h66);

      // Single-clock glitches on SCL and SDA must not disturb a transfer.
      base_rx = rxv_cnt;
      m_sda_low = 1'b1;
      @(negedge clk);
      m_sda_low = 1'b0;
      wait_q();
      checkOutput("t6_idle_glitch_busy", busy, 1'b0);
      glitch_scl = 1'b1;
      glitch_sda = 1'b1;
      i2c_start();
      write_byte(8'h84, ack);
      checkOutput("t6_addr_ack", ack, 1'b0);
      write_byte(8'hB7, ack);
      checkOutput("t6_data_ack", ack, 1'b0);
      glitch_scl = 1'b0;
      glitch_sda = 1'b0;
      i2c_stop();
      checkOutput("t6_rx_valid_count", rxv_cnt - base_rx, 1);
      checkOutput("t6_rx_data", rx_data, 8'hB7);

      // Reset while the slave holds the address ACK low.
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(((8'h84 >> i) & 8'h01) != 0);
      m_sda_low = 1'b0;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      checkOutput("t7_ack_driven", sda, 1'b0);
      checkOutput("t7_busy_before_reset", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("t7_sda_released", sda, 1'b1);
      checkOutput("t7_busy_cleared", busy, 1'b0);
      checkOutput("t7_rx_data_cleared", rx_data, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      scl_m = 1'b0;
      wait_q();
      i2c_stop();
      checkOutput("t7_busy_after_stop", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
